// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector for one IMG_W x IMG_H frame per reset.
// Define SOBEL_BINARY_EN for a thresholded 0/255 output instead of magnitude.
module sobel_edge_detect #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int THRESHOLD = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_data,
  output logic       busy,
  output logic       valid,
  output logic [7:0] edge_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] S_LOAD2 = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef SOBEL_BINARY_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  localparam logic [CW+1:0] N_ROW  = (CW+2)'(IMG_W);
  localparam logic [CW+1:0] N_ROW2 = (CW+2)'(2 * IMG_W);
  localparam logic [11:0]   THR    = 12'(THRESHOLD);

  logic [1:0]    state;
  logic [CW+1:0] rq;
  logic          pend;
  logic [CW-1:0] wr_col;
  logic [1:0]    wr_buf;
  logic [CW-1:0] ccol;
  logic [RW-1:0] crow;
  logic [1:0]    mid_buf;
  logic [7:0]    line [3][IMG_W];

  logic          req;
  logic          last_wr;

  function automatic logic [1:0] nxt3(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  always_comb begin
    busy = 1'b1;
    if (state == S_LOAD2)
      busy = (rq == N_ROW2);
    else if (state == S_LOAD)
      busy = (rq == N_ROW);
  end

  assign req = ~busy;
  // busy rises with the last request, so pend here marks the final pixel
  assign last_wr = pend && busy;

  always_ff @(posedge clk) begin
    if (pend)
      line[wr_buf][wr_col] <= pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD2;
      rq      <= '0;
      pend    <= 1'b0;
      wr_col  <= '0;
      wr_buf  <= 2'd0;
      ccol    <= '0;
      crow    <= '0;
      mid_buf <= 2'd0;
    end else begin
      pend <= req;
      if (req)
        rq <= rq + 1'b1;
      if (pend) begin
        if (wr_col == CW'(IMG_W - 1)) begin
          wr_col <= '0;
          wr_buf <= nxt3(wr_buf);
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      unique case (state)
        S_LOAD2, S_LOAD: begin
          if (last_wr)
            state <= S_CALC;
        end
        S_CALC: begin
          if (ccol == CW'(IMG_W - 1)) begin
            ccol    <= '0;
            crow    <= crow + 1'b1;
            mid_buf <= nxt3(mid_buf);
            if (crow == RW'(IMG_H - 1)) begin
              state <= S_DONE;
            end else if (crow == RW'(IMG_H - 2)) begin
              state <= S_CALC;
            end else begin
              state <= S_LOAD;
              rq    <= '0;
            end
          end else begin
            ccol <= ccol + 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  logic [1:0]    rb [3];
  logic          re [3];
  logic [CW-1:0] ci [3];
  logic          ce [3];
  logic [7:0]    w  [3][3];

  always_comb begin
    rb[0] = (mid_buf == 2'd0) ? 2'd2 : mid_buf - 2'd1;
    rb[1] = mid_buf;
    rb[2] = nxt3(mid_buf);
    re[0] = (crow != '0);
    re[1] = 1'b1;
    re[2] = (crow != RW'(IMG_H - 1));
    ci[0] = ccol - 1'b1;
    ci[1] = ccol;
    ci[2] = ccol + 1'b1;
    ce[0] = (ccol != '0);
    ce[1] = 1'b1;
    ce[2] = (ccol != CW'(IMG_W - 1));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = (re[i] && ce[j]) ? line[rb[i]][ci[j]] : 8'd0;
  end

  logic [9:0]         sl, sr, st, sb;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [7:0]         res;

  always_comb begin
    sl  = {2'b0, w[0][0]} + {1'b0, w[1][0], 1'b0} + {2'b0, w[2][0]};
    sr  = {2'b0, w[0][2]} + {1'b0, w[1][2], 1'b0} + {2'b0, w[2][2]};
    st  = {2'b0, w[0][0]} + {1'b0, w[0][1], 1'b0} + {2'b0, w[0][2]};
    sb  = {2'b0, w[2][0]} + {1'b0, w[2][1], 1'b0} + {2'b0, w[2][2]};
    gx  = $signed({1'b0, sr}) - $signed({1'b0, sl});
    gy  = $signed({1'b0, sb}) - $signed({1'b0, st});
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    if (BIN)
      res = (mag >= THR) ? 8'hFF : 8'h00;
    else
      res = (|mag[11:8]) ? 8'hFF : mag[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      edge_out <= 8'd0;
    end else begin
      valid    <= (state == S_CALC);
      edge_out <= (state == S_CALC) ? res : 8'd0;
    end
  end

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect: pull-source model, output capture,
// hand-computed pixel checks plus a reference model for ramp frames.
module tb_sobel_edge_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_data;
  logic       busy;
  logic       valid;
  logic [7:0] edge_out;

  always #5 clk = ~clk;

  sobel_edge_detect dut (
    .clk      (clk),
    .rst      (rst),
    .pix_data (pix_data),
    .busy     (busy),
    .valid    (valid),
    .edge_out (edge_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] frame [1024];
  logic [7:0] got   [1024];
  int n_out, n_req, post_req, post_valid;
  bit tmo;

  function automatic int px(int r, int c);
    if (r < 0 || r > 31 || c < 0 || c > 31)
      return 0;
    return int'(frame[r*32+c]);
  endfunction

  function automatic int gold(int r, int c);
    int gx, gy, m;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
       - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    pix_data = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_frame(input int abort_at);
    bit b;
    n_out = 0;
    n_req = 0;
    post_req = 0;
    post_valid = 0;
    tmo = 1'b0;
    for (int cyc = 0; n_out < 1024; cyc++) begin
      if (cyc >= 6000) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      if (valid) begin
        got[n_out] = edge_out;
        n_out++;
      end
      if (n_out == abort_at)
        return;
      b = busy;
      @(posedge clk);
      #1;
      if (!b) begin
        pix_data = frame[n_req % 1024];
        n_req++;
      end
    end
    repeat (40) begin
      @(negedge clk);
      if (!busy) post_req++;
      if (valid) post_valid++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pix_data = 8'd0;
    #2;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", valid);
    end
    n_cmp++;
    if (edge_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_edge got %0d want 0", edge_out);
    end
  endtask

  task automatic test_zero_frame;
    foreach (frame[i]) frame[i] = 8'd0;
    do_reset();
    run_frame(-1);
    n_cmp++;
    if (tmo || n_out !== 1024) begin
      n_bad++;
      $display("FAIL zero_count got %0d want 1024", n_out);
    end
    for (int i = 0; i < n_out; i++) begin
      n_cmp++;
      if (got[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL zero_pix[%0d] got %0d want 0", i, got[i]);
      end
    end
    n_cmp++;
    if (post_valid !== 0) begin
      n_bad++;
      $display("FAIL done_valid got %0d pulses want 0", post_valid);
    end
    n_cmp++;
    if (post_req !== 0) begin
      n_bad++;
      $display("FAIL done_busy got %0d busy-low want 0", post_req);
    end
  endtask

  task automatic test_const10;
    int rr [7] = '{0, 0, 5, 31, 0, 31, 10};
    int cc [7] = '{0, 5, 0, 31, 31, 0, 10};
    int ex [7] = '{60, 40, 40, 60, 60, 60, 0};
    foreach (frame[i]) frame[i] = 8'd10;
    do_reset();
    run_frame(-1);
    n_cmp++;
    if (tmo || n_out !== 1024) begin
      n_bad++;
      $display("FAIL c10_count got %0d want 1024", n_out);
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (got[rr[k]*32+cc[k]] !== 8'(ex[k])) begin
        n_bad++;
        $display("FAIL c10 (%0d,%0d) got %0d want %0d",
                 rr[k], cc[k], got[rr[k]*32+cc[k]], ex[k]);
      end
    end
  endtask

  task automatic test_const100;
    int rr [4] = '{0, 31, 0, 10};
    int cc [4] = '{0, 31, 5, 10};
    int ex [4] = '{255, 255, 255, 0};
    foreach (frame[i]) frame[i] = 8'd100;
    do_reset();
    run_frame(-1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tmo || got[rr[k]*32+cc[k]] !== 8'(ex[k])) begin
        n_bad++;
        $display("FAIL c100 (%0d,%0d) got %0d want %0d",
                 rr[k], cc[k], got[rr[k]*32+cc[k]], ex[k]);
      end
    end
  endtask

  task automatic test_step;
    int cc [4] = '{15, 16, 14, 17};
    int ex [4] = '{255, 255, 0, 0};
    foreach (frame[i]) frame[i] = ((i % 32) >= 16) ? 8'd200 : 8'd0;
    do_reset();
    run_frame(-1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tmo || got[5*32+cc[k]] !== 8'(ex[k])) begin
        n_bad++;
        $display("FAIL step (5,%0d) got %0d want %0d",
                 cc[k], got[5*32+cc[k]], ex[k]);
      end
    end
  endtask

  task automatic test_handshake_ramp;
    foreach (frame[i]) frame[i] = 8'(i);
    do_reset();
    run_frame(-1);
    n_cmp++;
    if (tmo || n_req !== 1024) begin
      n_bad++;
      $display("FAIL ramp_requests got %0d want 1024", n_req);
    end
    n_cmp++;
    if (post_req !== 0) begin
      n_bad++;
      $display("FAIL ramp_extra_req got %0d want 0", post_req);
    end
    for (int i = 0; i < n_out; i++) begin
      n_cmp++;
      if (got[i] !== 8'(gold(i / 32, i % 32))) begin
        n_bad++;
        $display("FAIL ramp_pix (%0d,%0d) got %0d want %0d",
                 i / 32, i % 32, got[i], gold(i / 32, i % 32));
      end
    end
  endtask

  task automatic test_abort_restart;
    foreach (frame[i]) frame[i] = 8'((i * 7) ^ (i / 32));
    do_reset();
    run_frame(10 * 32 + 5);
    n_cmp++;
    if (n_out !== 10 * 32 + 5) begin
      n_bad++;
      $display("FAIL abort_reach got %0d want %0d", n_out, 10 * 32 + 5);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || edge_out !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_clear got v=%b e=%0d want v=0 e=0", valid, edge_out);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy got %b want 0", busy);
    end
    do_reset();
    run_frame(-1);
    n_cmp++;
    if (tmo || n_req !== 1024 || n_out !== 1024) begin
      n_bad++;
      $display("FAIL restart_counts got req=%0d out=%0d want 1024/1024",
               n_req, n_out);
    end
    for (int i = 0; i < n_out; i++) begin
      n_cmp++;
      if (got[i] !== 8'(gold(i / 32, i % 32))) begin
        n_bad++;
        $display("FAIL restart_pix (%0d,%0d) got %0d want %0d",
                 i / 32, i % 32, got[i], gold(i / 32, i % 32));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_const10();
    test_const100();
    test_step();
    test_handshake_ramp();
    test_abort_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
